bus_responder: RTL and testbench
================================

# bus_responder

Memory-side responder for the SM83 core's bus. It decodes each CPU read or write to a region, serves WRAM, echo RAM, HRAM and IE internally, and forwards everything else to one external port. When configured in, it also runs the OAM DMA engine that takes the bus away from the CPU.

## Interface
Parameters:
- `WRAM_AW`, default 13: WRAM address width (8 KiB).
- `HRAM_DEPTH`, default 127: HRAM bytes at 0xFF80–0xFFFE.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `cpu_addr` in 16: CPU request address.
- `cpu_rd` in 1: CPU read request, sampled every cycle.
- `cpu_wr` in 1: CPU write request, sampled every cycle.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: registered read data.
- `ext_addr` out 16: external access address.
- `ext_rd` out 1: external read strobe.
- `ext_wr` out 1: external write strobe.
- `ext_wdata` out 8: external write data.
- `ext_region` out `bus_region_t`: decoded region of the current external access.
- `ext_rdata` in 8: external read data, combinational, same cycle as `ext_rd`.
- `ie` out 8: IE register (0xFFFF).
- `dma_active` out 1: OAM DMA in progress.

## Operation
- Decode, applied to the CPU address or the DMA address:
  - 0x0000–0x7FFF ROM: external.
  - 0x8000–0x9FFF VRAM: external.
  - 0xA000–0xBFFF CRAM: external.
  - 0xC000–0xDFFF WRAM: internal.
  - 0xE000–0xFDFF ECHO: internal, maps to WRAM at addr−0x2000.
  - 0xFE00–0xFE9F OAM: external.
  - 0xFEA0–0xFEFF UNMAPPED.
  - 0xFF00–0xFF7F IO: external, except 0xFF46 when DMA is enabled.
  - 0xFF80–0xFFFE HRAM: internal.
  - 0xFFFF IE: internal.
- UNMAPPED reads return 0xFF; UNMAPPED writes are dropped.
- If `cpu_rd` and `cpu_wr` are both high, the write executes, the read is ignored and `cpu_rdata` holds.
- External port:
  - `ext_addr`, `ext_wdata` and `ext_region` are driven combinationally from the current requester.
  - `ext_rd`/`ext_wr` are high only for accesses that decode to an external region.
  - With no request, strobes are 0 and `ext_addr` = `cpu_addr`.
- OAM DMA (when configured in):
  - A CPU write of V to 0xFF46 latches src = {V, 8'h00} and starts a transfer.
  - The transfer copies 160 bytes: src+i → 0xFE00+i, for i = 0..159.
  - While `dma_active`, the CPU may access only HRAM. Any other CPU read returns 0xFF; any other CPU write is dropped. The external port belongs to DMA.
  - A DMA source in 0xE000–0xFFFF reads through the echo/WRAM path for 0xE000–0xFDFF. For 0xFE00 and above, the source reads 0xFF.
- DMA states:
  - IDLE → START on a 0xFF46 write.
  - START → RD (one cycle).
  - RD: read byte i into a holding register. RD → WR.
  - WR: write byte i to OAM via the external port (`ext_wr`=1, region OAM). WR → RD with i+1 if i<159, otherwise → IDLE.
  - A 0xFF46 write in any non-IDLE state reloads src, clears i and goes to START.
- Index i is 8 bits; the source address is src + i with no carry past bit 15.

## Timing
- Reset values:
  - `cpu_rdata`=0xFF, `ie`=0x00, `dma_active`=0.
  - DMA state IDLE, i=0.
  - `ext_rd`/`ext_wr`=0 while `rst` is high.
  - WRAM and HRAM contents are not reset.
- Reads: request in cycle N. `cpu_rdata` is valid from N+1 and holds until the next accepted read.
- Writes: take effect at the clock edge ending cycle N. A read of the same address in N+1 returns the new value in N+2.
- DMA timing, for a 0xFF46 write in cycle N:
  - START in N+1; `dma_active` is 1 from N+1.
  - First RD in N+2; last WR in N+321.
  - `dma_active` is 0 from N+322.
- Reset asserted during DMA aborts it immediately. No further `ext_wr` occurs.

## Configuration
- `GB_OAM_DMA_EN`:
  - Defined: DMA engine, 0xFF46 interception and CPU bus lockout are as above.
  - Undefined: 0xFF46 is forwarded to the external port as ordinary IO, `dma_active` is tied to 0 and no lockout applies.

## Structure
- In `sm83_pkg`:
  - `bus_region_t` enum: REG_ROM, REG_VRAM, REG_CRAM, REG_WRAM, REG_ECHO, REG_OAM, REG_UNMAPPED, REG_IO, REG_HRAM, REG_IE.
  - `dma_state_t` enum: DMA_IDLE, DMA_START, DMA_RD, DMA_WR.
  - Region base/limit constants, `DMA_REG_ADDR` = 16'hFF46, `OAM_DMA_LEN` = 160.
- Sub-module `oam_dma`: state machine, index counter, source latch and holding register. It outputs a request (addr/rd/wr/wdata) that `bus_responder` muxes ahead of the CPU.

## Test plan
- Write 0x5A to 0xC123, then read 0xE123 → `cpu_rdata`=0x5A one cycle after the read.
- Write 0x1F to 0xFFFF → `ie`=0x1F; read 0xFEA5 → 0xFF; read 0x4000 with `ext_rdata`=0x3C → `ext_rd`=1, region ROM, `cpu_rdata`=0x3C.
- Preload 0xC000–0xC09F with i^0xA5, then write 0xC0 to 0xFF46 → exactly 160 `ext_wr` pulses:
  - addresses 0xFE00..0xFE9F with data i^0xA5;
  - `dma_active` high for 321 cycles.
- During DMA, read 0xC000 → 0xFF; write/read 0xFF90 → works.
- Mid-DMA (i=50), write 0xC1 to 0xFF46 → the next OAM write is address 0xFE00 with data from 0xC100.
- Assert `rst` mid-DMA → `dma_active`=0 and no `ext_wr` afterwards. Simultaneous `cpu_rd`+`cpu_wr` → write lands, `cpu_rdata` unchanged.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared types and address map for the SM83 memory-side bus.
package sm83_pkg;

    typedef enum logic [3:0] {
        REG_ROM, REG_VRAM, REG_CRAM, REG_WRAM, REG_ECHO,
        REG_OAM, REG_UNMAPPED, REG_IO, REG_HRAM, REG_IE
    } bus_region_t;

    typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_RD, DMA_WR} dma_state_t;

    localparam logic [15:0] ROM_LIMIT   = 16'h7FFF;
    localparam logic [15:0] VRAM_LIMIT  = 16'h9FFF;
    localparam logic [15:0] CRAM_LIMIT  = 16'hBFFF;
    localparam logic [15:0] WRAM_BASE   = 16'hC000;
    localparam logic [15:0] WRAM_LIMIT  = 16'hDFFF;
    localparam logic [15:0] ECHO_BASE   = 16'hE000;
    localparam logic [15:0] ECHO_LIMIT  = 16'hFDFF;
    localparam logic [15:0] OAM_BASE    = 16'hFE00;
    localparam logic [15:0] OAM_LIMIT   = 16'hFE9F;
    localparam logic [15:0] UNMAP_LIMIT = 16'hFEFF;
    localparam logic [15:0] IO_LIMIT    = 16'hFF7F;
    localparam logic [15:0] HRAM_BASE   = 16'hFF80;
    localparam logic [15:0] HRAM_LIMIT  = 16'hFFFE;
    localparam logic [15:0] IE_ADDR     = 16'hFFFF;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam int          OAM_DMA_LEN  = 160;

    function automatic bus_region_t region_of(input logic [15:0] a);
        bus_region_t r;
        if (a <= ROM_LIMIT)        r = REG_ROM;
        else if (a <= VRAM_LIMIT)  r = REG_VRAM;
        else if (a <= CRAM_LIMIT)  r = REG_CRAM;
        else if (a <= WRAM_LIMIT)  r = REG_WRAM;
        else if (a <= ECHO_LIMIT)  r = REG_ECHO;
        else if (a <= OAM_LIMIT)   r = REG_OAM;
        else if (a <= UNMAP_LIMIT) r = REG_UNMAPPED;
        else if (a <= IO_LIMIT)    r = REG_IO;
        else if (a <= HRAM_LIMIT)  r = REG_HRAM;
        else                       r = REG_IE;
        return r;
    endfunction

    function automatic logic is_external(input bus_region_t r);
        return r inside {REG_ROM, REG_VRAM, REG_CRAM, REG_OAM, REG_IO};
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies 160 bytes from {page,00} to OAM, alternating
// a read cycle into a holding register with a write cycle to OAM.
module oam_dma
    import sm83_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  start_page,
    input  logic [7:0]  rdata,
    output logic        active,
    output logic [15:0] req_addr,
    output logic        req_rd,
    output logic        req_wr,
    output logic [7:0]  req_wdata
);

    dma_state_t  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] src_addr;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        page_d    = page_q;
        hold_d    = hold_q;
        src_addr  = {page_q, 8'h00} + {8'h00, idx_q};
        req_addr  = src_addr;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_wdata = hold_q;
        case (state_q)
            DMA_START: begin
                idx_d   = '0;
                state_d = DMA_RD;
            end
            DMA_RD: begin
                // Sources at 0xFE00 and above are not read; they supply 0xFF.
                req_rd  = (src_addr < OAM_BASE);
                hold_d  = req_rd ? rdata : 8'hFF;
                state_d = DMA_WR;
            end
            DMA_WR: begin
                req_wr   = 1'b1;
                req_addr = OAM_BASE + {8'h00, idx_q};
                if (idx_q == 8'(OAM_DMA_LEN - 1)) begin
                    idx_d   = '0;
                    state_d = DMA_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = DMA_RD;
                end
            end
            default: state_d = DMA_IDLE;
        endcase
        if (start) begin
            page_d  = start_page;
            idx_d   = '0;
            state_d = DMA_START;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            idx_q   <= '0;
            page_q  <= '0;
            hold_q  <= 8'hFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            hold_q  <= hold_d;
        end
    end

    assign active = (state_q != DMA_IDLE);

endmodule

// File: rtl/bus_responder.sv
// SM83 bus responder: internal WRAM/echo/HRAM/IE, external forwarding,
// and optional OAM DMA enabled by the GB_OAM_DMA_EN macro.
module bus_responder
    import sm83_pkg::*;
#(
    parameter int WRAM_AW    = 13,
    parameter int HRAM_DEPTH = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] ext_addr,
    output logic        ext_rd,
    output logic        ext_wr,
    output logic [7:0]  ext_wdata,
    output bus_region_t ext_region,
    input  logic [7:0]  ext_rdata,
    output logic [7:0]  ie,
    output logic        dma_active
);

    localparam int HAW = $clog2(HRAM_DEPTH);
`ifdef GB_OAM_DMA_EN
    localparam bit DMA_EN = 1'b1;
`else
    localparam bit DMA_EN = 1'b0;
`endif

    logic [7:0] wram_mem [2**WRAM_AW];
    logic [7:0] hram_mem [HRAM_DEPTH];

    logic [7:0]   cpu_rdata_q, cpu_rdata_d, ie_q, ie_d;
    bus_region_t  cpu_region;
    logic         ff46_hit, locked, cpu_ext, cpu_rd_en, wr_ok;
    logic         dma_rd, dma_wr;
    logic [15:0]  dma_addr;
    logic [7:0]   dma_wdata;
    logic [15:0]  req_addr, hram_off;
    logic         req_rd, req_wr;
    logic [7:0]   req_wdata;
    logic         wram_we, hram_we;
    logic [WRAM_AW-1:0] wram_wa;
    logic [HAW-1:0]     hram_wa;

    function automatic logic [WRAM_AW-1:0] wram_idx(input logic [15:0] a);
        return WRAM_AW'(a - ((region_of(a) == REG_ECHO) ? ECHO_BASE : WRAM_BASE));
    endfunction

    function automatic logic [7:0] int_rd(input logic [15:0] a);
        logic [7:0]  v;
        logic [15:0] ho;
        v  = 8'hFF;
        ho = a - HRAM_BASE;
        case (region_of(a))
            REG_WRAM, REG_ECHO: v = wram_mem[wram_idx(a)];
            REG_HRAM: if (ho < 16'(HRAM_DEPTH)) v = hram_mem[HAW'(ho)];
            REG_IE:   v = ie_q;
            default:  v = 8'hFF;
        endcase
        return v;
    endfunction

    always_comb begin
        cpu_region = region_of(cpu_addr);
        cpu_rd_en  = cpu_rd && !cpu_wr;
        ff46_hit   = DMA_EN && (cpu_addr == DMA_REG_ADDR);
        // While DMA owns the bus the CPU only sees HRAM.
        locked     = dma_active && (cpu_region != REG_HRAM);
        cpu_ext    = is_external(cpu_region) && !ff46_hit && !locked;

        if (dma_rd || dma_wr) begin
            req_addr  = dma_addr;
            req_rd    = dma_rd;
            req_wr    = dma_wr;
            req_wdata = dma_wdata;
        end else begin
            req_addr  = cpu_addr;
            req_rd    = cpu_rd_en && cpu_ext;
            req_wr    = cpu_wr && cpu_ext;
            req_wdata = cpu_wdata;
        end
        ext_addr   = req_addr;
        ext_wdata  = req_wdata;
        ext_region = region_of(req_addr);
        ext_rd     = req_rd && is_external(ext_region) && !rst;
        ext_wr     = req_wr && is_external(ext_region) && !rst;

        cpu_rdata_d = cpu_rdata_q;
        if (cpu_rd_en)
            cpu_rdata_d = cpu_ext ? ext_rdata : (locked ? 8'hFF : int_rd(cpu_addr));

        wr_ok    = cpu_wr && !locked;
        hram_off = cpu_addr - HRAM_BASE;
        wram_wa  = wram_idx(cpu_addr);
        hram_wa  = HAW'(hram_off);
        wram_we  = wr_ok && (cpu_region inside {REG_WRAM, REG_ECHO});
        hram_we  = wr_ok && (cpu_region == REG_HRAM) && (hram_off < 16'(HRAM_DEPTH));
        ie_d     = (wr_ok && cpu_region == REG_IE) ? cpu_wdata : ie_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q <= 8'hFF;
            ie_q        <= 8'h00;
        end else begin
            cpu_rdata_q <= cpu_rdata_d;
            ie_q        <= ie_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wram_we) wram_mem[wram_wa] <= cpu_wdata;
        if (hram_we) hram_mem[hram_wa] <= cpu_wdata;
    end

    assign cpu_rdata = cpu_rdata_q;
    assign ie        = ie_q;

`ifdef GB_OAM_DMA_EN
    logic [7:0] dma_rdata;
    logic       dma_start;
    assign dma_rdata = is_external(region_of(dma_addr)) ? ext_rdata : int_rd(dma_addr);
    assign dma_start = cpu_wr && (cpu_addr == DMA_REG_ADDR);

    oam_dma u_oam_dma (
        .clk        (clk),
        .rst        (rst),
        .start      (dma_start),
        .start_page (cpu_wdata),
        .rdata      (dma_rdata),
        .active     (dma_active),
        .req_addr   (dma_addr),
        .req_rd     (dma_rd),
        .req_wr     (dma_wr),
        .req_wdata  (dma_wdata)
    );
`else
    assign dma_active = 1'b0;
    assign dma_addr   = 16'h0000;
    assign dma_rd     = 1'b0;
    assign dma_wr     = 1'b0;
    assign dma_wdata  = 8'h00;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Randomized bench for bus_responder against an address-map reference model;
// OAM DMA scenarios run when GB_OAM_DMA_EN is defined.
module tb_bus_responder;
    import sm83_pkg::*;

`ifdef GB_OAM_DMA_EN
    localparam bit DMA_ON = 1'b1;
`else
    localparam bit DMA_ON = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00, salt = 8'h00;
    logic [7:0]  cpu_rdata, ext_wdata, ext_rdata, ie;
    logic [15:0] ext_addr;
    logic        ext_rd, ext_wr, dma_active;
    bus_region_t ext_region;

    int n_chk = 0, n_fail = 0;

    logic [7:0] wram_m [8192];
    bit         wram_v [8192];
    logic [7:0] hram_m [127];
    bit         hram_v [127];
    logic [7:0] ie_m = 8'h00, rdata_m = 8'hFF;
    bit         rdata_k = 1'b1;

    logic [15:0] wq_a [$];
    logic [7:0]  wq_d [$];
    int          bad_region = 0, act_cnt = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    // External device: data is a function of the address it is handed.
    assign ext_rdata = ext_addr[7:0] ^ ext_addr[15:8] ^ salt;

    bus_responder dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ext_addr(ext_addr),
        .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_wdata(ext_wdata),
        .ext_region(ext_region), .ext_rdata(ext_rdata), .ie(ie), .dma_active(dma_active)
    );

    always @(negedge clk) if (mon_en) begin
        if (ext_wr) begin
            wq_a.push_back(ext_addr);
            wq_d.push_back(ext_wdata);
            if (ext_region != REG_OAM) bad_region++;
        end
        if (dma_active) act_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bus_region_t m_region(input logic [15:0] a);
        if (a < 16'h8000) return REG_ROM;
        if (a < 16'hA000) return REG_VRAM;
        if (a < 16'hC000) return REG_CRAM;
        if (a < 16'hE000) return REG_WRAM;
        if (a < 16'hFE00) return REG_ECHO;
        if (a < 16'hFEA0) return REG_OAM;
        if (a < 16'hFF00) return REG_UNMAPPED;
        if (a < 16'hFF80) return REG_IO;
        if (a < 16'hFFFF) return REG_HRAM;
        return REG_IE;
    endfunction

    function automatic bit m_ext(input logic [15:0] a);
        bus_region_t r = m_region(a);
        if (r == REG_IO) return !(DMA_ON && a == 16'hFF46);
        return r inside {REG_ROM, REG_VRAM, REG_CRAM, REG_OAM};
    endfunction

    task automatic m_read(input logic [15:0] a, output logic [7:0] v, output bit k);
        int h;
        h = int'(a) - 'hFF80;
        k = 1'b1;
        v = 8'hFF;
        if (a >= 16'hC000 && a < 16'hFE00) begin
            v = wram_m[a[12:0]];
            k = wram_v[a[12:0]];
        end else if (a >= 16'hFF80 && a != 16'hFFFF) begin
            v = hram_m[h];
            k = hram_v[h];
        end else if (a == 16'hFFFF) v = ie_m;
        else if (m_ext(a)) v = a[7:0] ^ a[15:8] ^ salt;
    endtask

    task automatic m_write(input logic [15:0] a, input logic [7:0] d);
        int h;
        h = int'(a) - 'hFF80;
        if (a >= 16'hC000 && a < 16'hFE00) begin
            wram_m[a[12:0]] = d;
            wram_v[a[12:0]] = 1'b1;
        end else if (a >= 16'hFF80 && a != 16'hFFFF) begin
            hram_m[h] = d;
            hram_v[h] = 1'b1;
        end else if (a == 16'hFFFF) ie_m = d;
    endtask

    // One CPU cycle outside DMA, checked against the model.
    task automatic cpu_op(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
        logic [7:0] v;
        bit k, ex;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        ex = m_ext(a);
        m_read(a, v, k);
        @(negedge clk);
        chk("ext_rd", ext_rd, rd && !wr && ex);
        chk("ext_wr", ext_wr, wr && ex);
        if (!rd && !wr) chk("ext_addr_idle", ext_addr, a);
        if (ex && (rd || wr)) begin
            chk("ext_addr", ext_addr, a);
            chk("ext_region", ext_region, m_region(a));
        end
        if (ex && wr) chk("ext_wdata", ext_wdata, d);
        @(posedge clk); #1;
        if (wr) m_write(a, d);
        else if (rd) begin rdata_m = v; rdata_k = k; end
        if (rdata_k) chk("cpu_rdata", cpu_rdata, rdata_m);
        chk("ie", ie, ie_m);
        chk("dma_idle", dma_active, 1'b0);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic step(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] off, a;
        off = 16'($urandom_range(0, 7));
        case ($urandom_range(0, 12))
            0:  a = 16'h4000 + off;
            1:  a = 16'h8000 + off;
            2:  a = 16'hA000 + off;
            3:  a = 16'hC000 + off;
            4:  a = 16'hE000 + off;
            5:  a = 16'hDFF8 + off;
            6:  a = 16'hFE98 + off;
            7:  a = 16'hFF40 + off;
            8:  a = 16'hFF78 + off;
            9:  a = 16'hFFF8 + off;
            10: a = 16'hFDF8 + off;
            11: a = 16'hFF80 + off;
            default: a = 16'hFEA0 + off;
        endcase
        if (DMA_ON && a == 16'hFF46) a = 16'hFF47;
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  restarted;
        // Reset, with a ROM read held to show strobes stay low.
        rst = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h4000;
        @(negedge clk);
        chk("rst_ext_rd", ext_rd, 1'b0);
        chk("rst_ext_wr", ext_wr, 1'b0);
        @(posedge clk); #1;
        chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
        chk("rst_ie", ie, 8'h00);
        chk("rst_dma_active", dma_active, 1'b0);
        rst = 1'b0; cpu_rd = 1'b0;

        cpu_op(0, 1, 16'hC123, 8'h5A);
        cpu_op(1, 0, 16'hE123, 8'h00);
        chk("echo_rd", cpu_rdata, 8'h5A);
        cpu_op(0, 1, 16'hFFFF, 8'h1F);
        chk("ie_wr", ie, 8'h1F);
        cpu_op(1, 0, 16'hFEA5, 8'h00);
        chk("unmapped_rd", cpu_rdata, 8'hFF);
        salt = 8'h7C;
        cpu_op(1, 0, 16'h4000, 8'h00);
        chk("rom_rd", cpu_rdata, 8'h3C);
        cpu_op(1, 0, 16'hC123, 8'h00);
        cpu_op(1, 1, 16'hC124, 8'h99);
        chk("rdwr_hold", cpu_rdata, 8'h5A);
        cpu_op(1, 0, 16'hC124, 8'h00);
        chk("rdwr_landed", cpu_rdata, 8'h99);

        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 3);
            salt = 8'($urandom);
            cpu_op(op == 1 || op == 3, op >= 2, pick_addr(), 8'($urandom));
        end

        if (DMA_ON) begin
            for (int i = 0; i < 160; i++) cpu_op(0, 1, 16'hC000 + 16'(i), 8'(i) ^ 8'hA5);
            for (int i = 0; i < 160; i++) cpu_op(0, 1, 16'hC100 + 16'(i), 8'(i * 7 + 3));
            cpu_op(1, 0, 16'hC005, 8'h00);
            chk("pre_dma_rd", cpu_rdata, 8'hA0);

            // Full transfer with CPU activity during lockout.
            wq_a.delete(); wq_d.delete(); act_cnt = 0; bad_region = 0; mon_en = 1'b1;
            step(0, 1, 16'hFF46, 8'hC0);
            chk("dma_start", dma_active, 1'b1);
            for (int k = 0; k < 340; k++) begin
                if (k == 10) begin
                    step(1, 0, 16'hC000, 8'h00);
                    chk("locked_rd", cpu_rdata, 8'hFF);
                end else if (k == 20) step(0, 1, 16'hFF90, 8'h77);
                else if (k == 21) begin
                    step(1, 0, 16'hFF90, 8'h00);
                    chk("hram_in_dma", cpu_rdata, 8'h77);
                end else if (k == 30) step(0, 1, 16'hC000, 8'h11);
                else step(0, 0, 16'h0000, 8'h00);
            end
            m_write(16'hFF90, 8'h77);
            chk("dma_done", dma_active, 1'b0);
            chk("dma_active_cycles", 16'(act_cnt), 16'd321);
            chk("dma_wr_count", 16'(wq_a.size()), 16'd160);
            chk("dma_wr_region", 16'(bad_region), 16'd0);
            for (int i = 0; i < 160 && i < wq_a.size(); i++) begin
                chk("dma_addr", wq_a[i], 16'hFE00 + 16'(i));
                chk("dma_data", wq_d[i], 8'(i) ^ 8'hA5);
            end
            cpu_op(1, 0, 16'hC000, 8'h00);
            chk("locked_wr_dropped", cpu_rdata, 8'hA5);

            // Restart at i=50 from page 0xC1.
            wq_a.delete(); wq_d.delete(); restarted = 1'b0;
            step(0, 1, 16'hFF46, 8'hC0);
            for (int k = 0; k < 500; k++) begin
                if (!restarted && wq_a.size() > 0 && wq_a[wq_a.size()-1] == 16'hFE32) begin
                    restarted = 1'b1;
                    step(0, 1, 16'hFF46, 8'hC1);
                end else step(0, 0, 16'h0000, 8'h00);
            end
            chk("restart_seen", restarted, 1'b1);
            chk("restart_wr_count", 16'(wq_a.size()), 16'd211);
            if (wq_a.size() == 211) begin
                chk("restart_last_old", wq_d[50], 8'd50 ^ 8'hA5);
                for (int j = 0; j < 160; j++) begin
                    chk("restart_addr", wq_a[51+j], 16'hFE00 + 16'(j));
                    chk("restart_data", wq_d[51+j], 8'(j * 7 + 3));
                end
            end

            // Reset aborts a transfer in progress.
            wq_a.delete(); wq_d.delete();
            step(0, 1, 16'hFF46, 8'hC0);
            for (int k = 0; k < 20; k++) step(0, 0, 16'h0000, 8'h00);
            rst = 1'b1;
            @(negedge clk);
            chk("rst_mid_dma_ext_wr", ext_wr, 1'b0);
            @(posedge clk); #1;
            rst = 1'b0;
            ie_m = 8'h00; rdata_m = 8'hFF; rdata_k = 1'b1;
            chk("rst_dma_abort", dma_active, 1'b0);
            n = wq_a.size();
            for (int k = 0; k < 40; k++) step(0, 0, 16'h0000, 8'h00);
            chk("no_wr_after_rst", 16'(wq_a.size()), 16'(n));
            chk("dma_stays_idle", dma_active, 1'b0);
            mon_en = 1'b0;
            cpu_op(1, 0, 16'hFF90, 8'h00);
            chk("hram_after_rst", cpu_rdata, 8'h77);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
